// File: rtl/data_memory_bytelane.sv
// Purpose : MEM-stage data memory with byte/half/word loads and stores, sign/zero extension,
//           misalignment/range fault detection, and an optional zeroing sweep after reset.
// Latency : loads are combinational (same cycle); stores, mem_fault and fault_addr update on clk.
// Backpressure: mem_busy=1 while the clear sweep runs; the pipeline must stall, stores are dropped.
//
// Ports:
//   clk, rst        single clock; synchronous active-low reset
//   alu_out_m       byte address (little-endian; lane = [1:0])
//   write_data_m    right-justified store data
//   mem_write_m/mem_read_m/mem_size_m/mem_unsigned_m   access request and type
//   read_data_m     extended load data (0 when no valid load)
//   mem_busy        clear sweep in progress
//   mem_fault       one-cycle pulse after a faulting access
//   fault_addr      address of the most recent faulting access
module data_memory_bytelane #(
   parameter int ADDR_W         = 32,
   parameter int DEPTH          = 1024,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] alu_out_m,
   input  logic [31:0]       write_data_m,
   input  logic              mem_write_m,
   input  logic              mem_read_m,
   input  logic [1:0]        mem_size_m,
   input  logic              mem_unsigned_m,
   output logic [31:0]       read_data_m,
   output logic              mem_busy,
   output logic              mem_fault,
   output logic [ADDR_W-1:0] fault_addr
);

   localparam int IDX_W = $clog2(DEPTH);
   // One bit wider than the address so DEPTH*4 never wraps in the range compare.
   localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH) << 2;

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
   logic              mem_fault_q, mem_fault_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

   logic [31:0]       mem_words [DEPTH];

   logic [IDX_W-1:0]  word_idx;
   logic [1:0]        lane;
   logic [31:0]       rd_word;
   logic              ready;
   logic              access;
   logic              bad_align;
   logic              out_of_range;
   logic              fault;

   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [3:0]        wr_be;
   logic [31:0]       wr_dat;

   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;

   assign word_idx = alu_out_m[IDX_W+1:2];
   assign lane     = alu_out_m[1:0];
   assign rd_word  = mem_words[word_idx];
   assign ready    = (state_q == READY);
   assign access   = mem_read_m | mem_write_m;

   // Fault decode; suppressed while the sweep owns the array.
   always_comb begin
      bad_align = 1'b0;
      case (mem_size_m)
         2'b00:   bad_align = 1'b0;
         2'b01:   bad_align = lane[0];
         2'b10:   bad_align = (lane != 2'b00);
         default: bad_align = 1'b1;
      endcase
      out_of_range = ({1'b0, alu_out_m} >= MEM_BYTES);
      fault        = ready & access & (bad_align | out_of_range);
   end

   // Load path: lane select then extension.
   always_comb begin
      sel_byte = rd_word[7:0];
      case (lane)
         2'd0: sel_byte = rd_word[7:0];
         2'd1: sel_byte = rd_word[15:8];
         2'd2: sel_byte = rd_word[23:16];
         2'd3: sel_byte = rd_word[31:24];
      endcase
      sel_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
      read_data_m = 32'h0;
      if (ready & mem_read_m & ~fault) begin
         case (mem_size_m)
            2'b00:   read_data_m = mem_unsigned_m ? {24'h0, sel_byte}
                                                  : {{24{sel_byte[7]}}, sel_byte};
            2'b01:   read_data_m = mem_unsigned_m ? {16'h0, sel_half}
                                                  : {{16{sel_half[15]}}, sel_half};
            default: read_data_m = rd_word;
         endcase
      end
   end

   // Next-state and array write port. The sweep and CPU stores share one port;
   // nothing is written while reset is held.
   always_comb begin
      state_d      = state_q;
      clr_idx_d    = clr_idx_q;
      mem_fault_d  = fault;
      fault_addr_d = fault ? alu_out_m : fault_addr_q;
      wr_en        = 1'b0;
      wr_idx       = word_idx;
      wr_be        = 4'b0000;
      wr_dat       = 32'h0;
      case (state_q)
         CLEAR: begin
            wr_en     = rst;
            wr_idx    = clr_idx_q;
            wr_be     = 4'b1111;
            wr_dat    = 32'h0;
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH-1)) begin
               state_d = READY;
            end
         end
         READY: begin
            if (mem_write_m & ~fault) begin
               wr_en = rst;
               case (mem_size_m)
                  2'b00: begin
                     wr_be  = 4'b0001 << lane;
                     wr_dat = {4{write_data_m[7:0]}};
                  end
                  2'b01: begin
                     wr_be  = lane[1] ? 4'b1100 : 4'b0011;
                     wr_dat = {2{write_data_m[15:0]}};
                  end
                  default: begin
                     wr_be  = 4'b1111;
                     wr_dat = write_data_m;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= CLEAR_ON_RESET ? CLEAR : READY;
         clr_idx_q    <= '0;
         mem_fault_q  <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         clr_idx_q    <= clr_idx_d;
         mem_fault_q  <= mem_fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
               mem_words[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
            end
         end
      end
   end

   assign mem_busy   = (state_q == CLEAR);
   assign mem_fault  = mem_fault_q;
   assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane: directed vector table, reset/sweep sequences,
// and random accesses against a byte-array reference model.
module tb_data_memory_bytelane;
   localparam int ADDR_W    = 32;
   localparam int DEPTH     = 64;
   localparam int MEM_BYTES = DEPTH * 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] alu_out_m;
   logic [31:0]       write_data_m;
   logic              mem_write_m;
   logic              mem_read_m;
   logic [1:0]        mem_size_m;
   logic              mem_unsigned_m;
   logic [31:0]       read_data_m;
   logic              mem_busy;
   logic              mem_fault;
   logic [ADDR_W-1:0] fault_addr;

   always #5 clk = ~clk;

   data_memory_bytelane #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst(rst), .alu_out_m(alu_out_m), .write_data_m(write_data_m),
      .mem_write_m(mem_write_m), .mem_read_m(mem_read_m), .mem_size_m(mem_size_m),
      .mem_unsigned_m(mem_unsigned_m), .read_data_m(read_data_m), .mem_busy(mem_busy),
      .mem_fault(mem_fault), .fault_addr(fault_addr)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] model_mem [MEM_BYTES];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic        re;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] exp_rd;
      logic        exp_f;
      logic [31:0] exp_fa;
   } vec_t;
   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic re, input logic [1:0] sz, input logic uns);
      alu_out_m      = a;
      write_data_m   = wd;
      mem_write_m    = we;
      mem_read_m     = re;
      mem_size_m     = sz;
      mem_unsigned_m = uns;
   endtask

   task automatic idle();
      drive(32'h0, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0);
   endtask

   task automatic add(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re,
                      input logic [1:0] sz, input logic uns, input logic [31:0] erd,
                      input logic ef, input logic [31:0] efa);
      vec_t v;
      v.addr = a; v.wdata = wd; v.we = we; v.re = re; v.sz = sz; v.uns = uns;
      v.exp_rd = erd; v.exp_f = ef; v.exp_fa = efa;
      vq.push_back(v);
   endtask

   // Reference model: memory as a flat little-endian byte array.
   function automatic bit m_fault(input logic [31:0] a, input logic [1:0] sz, input bit acc);
      if (!acc) return 1'b0;
      if (sz == 2'd3) return 1'b1;
      if (a >= 32'(MEM_BYTES)) return 1'b1;
      if ((a % (32'd1 << sz)) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
      int nb = 1 << sz;
      logic [31:0] v = 32'h0;
      for (int k = 0; k < nb; k++) v = v | (32'(model_mem[a + k]) << (8 * k));
      if (nb == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
      if (nb == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic m_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
      logic [31:0] v;
      for (int k = 0; k < (1 << sz); k++) begin
         v = wd >> (8 * k);
         model_mem[a + k] = v[7:0];
      end
   endtask

   task automatic m_clear();
      for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [31:0] a, wd, exp_rd, exp_fa;
      logic [1:0]  sz;
      logic        we, re, uns, f;

      // Reset held for 3 cycles, then the sweep length is measured.
      rst = 1'b0;
      idle();
      repeat (3) tick();
      check("reset_busy", mem_busy, 1);
      check("reset_fault", mem_fault, 0);
      check("reset_faddr", fault_addr, 0);
      check("reset_rdata", read_data_m, 0);
      rst = 1'b1;
      n = 0;
      while (n < 4 * DEPTH) begin
         tick();
         n++;
         if (!mem_busy) break;
      end
      check("sweep_len", n, DEPTH);
      m_clear();
      foreach (vq[i]) vq.delete(i);
      drive(32'h0, 0, 0, 1, 2, 0);                 #1; check("zero_0x0", read_data_m, 0);
      drive(32'h4, 0, 0, 1, 2, 0);                 #1; check("zero_0x4", read_data_m, 0);
      drive(32'((DEPTH-1)*4), 0, 0, 1, 2, 0);      #1; check("zero_last", read_data_m, 0);

      // Directed vector table: addr, wdata, we, re, size, uns, exp read, exp fault, exp fault_addr.
      add(32'h10, 32'h8BADF00D, 1, 0, 2, 0, 32'h0,        0, 32'h0);
      add(32'h10, 32'h0,        0, 1, 0, 0, 32'h0000000D, 0, 32'h0);
      add(32'h11, 32'h0,        0, 1, 0, 0, 32'hFFFFFFF0, 0, 32'h0);
      add(32'h13, 32'h0,        0, 1, 0, 1, 32'h0000008B, 0, 32'h0);
      add(32'h12, 32'h0,        0, 1, 1, 0, 32'hFFFF8BAD, 0, 32'h0);
      add(32'h10, 32'h0,        0, 1, 1, 1, 32'h0000F00D, 0, 32'h0);
      add(32'h10, 32'h0,        0, 1, 2, 1, 32'h8BADF00D, 0, 32'h0);
      add(32'h20, 32'h11223344, 1, 0, 2, 0, 32'h0,        0, 32'h0);
      add(32'h21, 32'h123456AA, 1, 0, 0, 0, 32'h0,        0, 32'h0);
      add(32'h22, 32'hDEADBEEF, 1, 0, 1, 0, 32'h0,        0, 32'h0);
      add(32'h20, 32'h0,        0, 1, 2, 0, 32'hBEEFAA44, 0, 32'h0);
      add(32'h21, 32'h0000FFFF, 1, 0, 1, 0, 32'h0,        1, 32'h21);
      add(32'h20, 32'h0,        0, 1, 2, 0, 32'hBEEFAA44, 0, 32'h21);
      add(32'(MEM_BYTES), 32'h12345678, 1, 0, 2, 0, 32'h0, 1, 32'(MEM_BYTES));
      add(32'(MEM_BYTES), 32'h0, 0, 1, 2, 0, 32'h0,       1, 32'(MEM_BYTES));
      add(32'h22, 32'h0,        0, 1, 2, 0, 32'h0,        1, 32'h22);
      add(32'h24, 32'h0,        0, 1, 3, 0, 32'h0,        1, 32'h24);
      add(32'h20, 32'h0,        0, 0, 2, 0, 32'h0,        0, 32'h24);
      add(32'h23, 32'h0,        0, 1, 0, 0, 32'hFFFFFFBE, 0, 32'h24);
      add(32'h22, 32'h0,        0, 1, 0, 1, 32'h000000EF, 0, 32'h24);
      add(32'h20, 32'h0,        0, 1, 1, 0, 32'hFFFFAA44, 0, 32'h24);
      add(32'h22, 32'h0,        0, 1, 1, 1, 32'h0000BEEF, 0, 32'h24);
      add(32'h08, 32'hCAFEBABE, 1, 0, 2, 0, 32'h0,        0, 32'h24);
      add(32'h08, 32'h00000005, 1, 1, 2, 0, 32'hCAFEBABE, 0, 32'h24);
      add(32'h08, 32'h0,        0, 1, 2, 0, 32'h00000005, 0, 32'h24);
      add(32'(MEM_BYTES-4), 32'hA5A5A5A5, 1, 0, 2, 0, 32'h0, 0, 32'h24);
      add(32'(MEM_BYTES-1), 32'h0, 0, 1, 0, 1, 32'h000000A5, 0, 32'h24);
      add(32'(MEM_BYTES-2), 32'h0, 0, 1, 1, 0, 32'hFFFFA5A5, 0, 32'h24);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].addr, vq[i].wdata, vq[i].we, vq[i].re, vq[i].sz, vq[i].uns);
         #1;
         check($sformatf("vec%0d_rdata", i), read_data_m, vq[i].exp_rd);
         tick();
         check($sformatf("vec%0d_fault", i), mem_fault, vq[i].exp_f);
         check($sformatf("vec%0d_faddr", i), fault_addr, vq[i].exp_fa);
         if (vq[i].we && !m_fault(vq[i].addr, vq[i].sz, 1'b1))
            m_store(vq[i].addr, vq[i].wdata, vq[i].sz);
      end

      // Random accesses against the byte-array model.
      exp_fa = 32'h24;
      for (int i = 0; i < 400; i++) begin
         a   = 32'($urandom_range(0, MEM_BYTES + 16));
         if ($urandom_range(0, 15) == 0) a = $urandom;
         wd  = $urandom;
         sz  = 2'($urandom_range(0, 3));
         we  = 1'($urandom_range(0, 1));
         re  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         f   = m_fault(a, sz, we | re);
         exp_rd = (re && !f) ? m_load(a, sz, uns) : 32'h0;
         if (f) exp_fa = a;
         drive(a, wd, we, re, sz, uns);
         #1;
         check($sformatf("rnd%0d_rdata", i), read_data_m, exp_rd);
         tick();
         check($sformatf("rnd%0d_fault", i), mem_fault, f);
         check($sformatf("rnd%0d_faddr", i), fault_addr, exp_fa);
         if (we && !f) m_store(a, wd, sz);
      end

      // Reset again, interrupt the sweep halfway, then check it restarts in full.
      idle();
      rst = 1'b0;
      tick();
      check("reset2_busy", mem_busy, 1);
      check("reset2_fault", mem_fault, 0);
      check("reset2_faddr", fault_addr, 0);
      rst = 1'b1;
      repeat (DEPTH / 2) tick();
      check("midsweep_busy", mem_busy, 1);
      rst = 1'b0;
      tick();
      check("midreset_busy", mem_busy, 1);
      rst = 1'b1;
      n = 0;
      while (n < 4 * DEPTH) begin
         if (n == 40) begin
            drive(32'h40, 32'h12345678, 1, 1, 2, 0);
            #1;
            check("busy_rdata", read_data_m, 0);
         end else if (n == 41) begin
            drive(32'h41, 32'h0, 1, 0, 2, 0);
         end else begin
            idle();
         end
         tick();
         n++;
         if (n == 42) check("busy_nofault", mem_fault, 0);
         if (!mem_busy) break;
      end
      check("resweep_len", n, DEPTH);
      drive(32'h40, 0, 0, 1, 2, 0); #1; check("busy_store_dropped", read_data_m, 0);
      drive(32'h20, 0, 0, 1, 2, 0); #1; check("resweep_zero_0x20", read_data_m, 0);
      drive(32'h08, 0, 0, 1, 2, 0); #1; check("resweep_zero_0x8", read_data_m, 0);
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
